// File: rtl/spi_if.sv
// SPI link and receive-side status bundle between the master-facing pins and the slave endpoint.
interface spi_if #(
  parameter int unsigned F_SIZE  = 8,
  parameter int unsigned FC_SIZE = 1
);
  logic               CS;
  logic               MOSI;
  logic               MISO;
  logic [F_SIZE-1:0]  tx_data_i;
  logic [F_SIZE-1:0]  rx_data_o;
  logic               rx_valid_o;
  logic               rx_toggle_o;
  logic [FC_SIZE-1:0] f_cnt_o;
  logic               done_o;
  logic               overrun_o;
  logic [1:0]         state_d;

  modport slave (
    input  CS, MOSI, tx_data_i,
    output MISO, rx_data_o, rx_valid_o, rx_toggle_o, f_cnt_o, done_o, overrun_o, state_d
  );

  modport master (
    output CS, MOSI, tx_data_i,
    input  MISO, rx_data_o, rx_valid_o, rx_toggle_o, f_cnt_o, done_o, overrun_o, state_d
  );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 MSB-first SPI receive endpoint clocked by the master's SCLK; deserializes F_NUM frames
// per chip-select transaction while shifting a transmit word out on MISO.
module spi_slave #(
  parameter int unsigned F_NUM   = 1,
  parameter int unsigned F_SIZE  = 8,
  parameter int unsigned C_SIZE  = $clog2(F_SIZE) + 1,
  parameter int unsigned FC_SIZE = $clog2(F_NUM) + 1
) (
  input  logic     SCLK,
  input  logic     rst,
  spi_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              fsm_q, fsm_d;
  logic [C_SIZE-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FC_SIZE-1:0]  f_cnt_q, f_cnt_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic [F_SIZE-2:0]   shift_q, shift_d;
  logic [F_SIZE-1:0]   tx_shift_q, tx_shift_d;
  logic [F_SIZE-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_toggle_q, rx_toggle_d;
  logic                clr;

  // Transaction state is cleared by either reset or chip-select release.
  assign clr = rst | bus.CS;

  always_comb begin
    fsm_d       = fsm_q;
    bit_cnt_d   = bit_cnt_q;
    f_cnt_d     = f_cnt_q;
    done_d      = done_q;
    overrun_d   = overrun_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_toggle_d = rx_toggle_q;

    unique case (fsm_q)
      IDLE, SHIFT: begin
        if (!bus.CS) begin
          if (fsm_q == IDLE || bit_cnt_q == '0) begin
            // First edge of a frame: capture the transmit word and drop valid.
            fsm_d      = SHIFT;
            shift_d    = (F_SIZE-1)'(bus.MOSI);
            bit_cnt_d  = C_SIZE'(1);
            tx_shift_d = bus.tx_data_i << 1;
            rx_valid_d = 1'b0;
          end else begin
            shift_d    = (F_SIZE-1)'({shift_q, bus.MOSI});
            tx_shift_d = tx_shift_q << 1;
            if (bit_cnt_q == C_SIZE'(F_SIZE-1)) begin
              rx_data_d   = {shift_q, bus.MOSI};
              rx_valid_d  = 1'b1;
              rx_toggle_d = ~rx_toggle_q;
              f_cnt_d     = f_cnt_q + FC_SIZE'(1);
              bit_cnt_d   = '0;
              if (f_cnt_d == FC_SIZE'(F_NUM)) begin
                done_d = 1'b1;
                fsm_d  = DONE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + C_SIZE'(1);
            end
          end
        end
      end
      DONE: begin
        overrun_d = 1'b1;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SCLK or posedge clr) begin
    if (clr) begin
      fsm_q      <= IDLE;
      bit_cnt_q  <= '0;
      f_cnt_q    <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      shift_q    <= '0;
      tx_shift_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      bit_cnt_q  <= bit_cnt_d;
      f_cnt_q    <= f_cnt_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // Received word and its handshake survive CS release; only reset clears them.
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_toggle_q <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_toggle_q <= rx_toggle_d;
    end
  end

  assign bus.MISO = (bus.CS || fsm_q == DONE) ? 1'b0 :
                    (bit_cnt_q == '0)         ? bus.tx_data_i[F_SIZE-1] :
                                                tx_shift_q[F_SIZE-1];

  assign bus.rx_data_o   = rx_data_q;
  assign bus.rx_valid_o  = rx_valid_q;
  assign bus.rx_toggle_o = rx_toggle_q;
  assign bus.f_cnt_o     = f_cnt_q;
  assign bus.done_o      = done_q;
  assign bus.overrun_o   = overrun_q;
  assign bus.state_d     = fsm_q;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave: two instances (one and two frames per transaction) driven in
// lockstep and compared against a transaction-level model.
module tb_spi_slave;
  localparam int unsigned FS = 8;

  logic          SCLK = 1'b0;
  logic          rst  = 1'b1;
  logic          cs   = 1'b1;
  logic          mosi = 1'b0;
  logic [FS-1:0] tx   = '0;

  spi_if #(.F_SIZE(FS), .FC_SIZE(1)) bus1 ();
  spi_if #(.F_SIZE(FS), .FC_SIZE(2)) bus2 ();

  assign bus1.CS = cs;  assign bus1.MOSI = mosi;  assign bus1.tx_data_i = tx;
  assign bus2.CS = cs;  assign bus2.MOSI = mosi;  assign bus2.tx_data_i = tx;

  spi_slave #(.F_NUM(1), .F_SIZE(FS)) dut1 (.SCLK(SCLK), .rst(rst), .bus(bus1));
  spi_slave #(.F_NUM(2), .F_SIZE(FS)) dut2 (.SCLK(SCLK), .rst(rst), .bus(bus2));

  // Model: edges seen in the current transaction plus the retained receive-side results.
  int            n;
  int            fnum [2] = '{1, 2};
  logic [FS-1:0] acc [2];
  logic [FS-1:0] m_rx [2];
  logic          m_valid [2];
  logic          m_tog [2];
  logic [FS-1:0] cap [2];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      int lim;
      int ef;
      int es;
      logic [31:0] g_rx, g_v, g_t, g_f, g_dn, g_ov, g_st;
      lim = fnum[d] * FS;
      ef  = (n / FS > fnum[d]) ? fnum[d] : n / FS;
      es  = (cs || n == 0) ? 0 : (n >= lim) ? 2 : 1;
      if (d == 0) begin
        g_rx = 32'(bus1.rx_data_o); g_v = 32'(bus1.rx_valid_o); g_t = 32'(bus1.rx_toggle_o);
        g_f = 32'(bus1.f_cnt_o); g_dn = 32'(bus1.done_o); g_ov = 32'(bus1.overrun_o);
        g_st = 32'(bus1.state_d);
      end else begin
        g_rx = 32'(bus2.rx_data_o); g_v = 32'(bus2.rx_valid_o); g_t = 32'(bus2.rx_toggle_o);
        g_f = 32'(bus2.f_cnt_o); g_dn = 32'(bus2.done_o); g_ov = 32'(bus2.overrun_o);
        g_st = 32'(bus2.state_d);
      end
      check($sformatf("d%0d rx_data", d),   g_rx, 32'(m_rx[d]));
      check($sformatf("d%0d rx_valid", d),  g_v,  32'(m_valid[d]));
      check($sformatf("d%0d rx_toggle", d), g_t,  32'(m_tog[d]));
      check($sformatf("d%0d f_cnt", d),     g_f,  32'(ef));
      check($sformatf("d%0d done", d),      g_dn, 32'((!cs && n >= lim) ? 1 : 0));
      check($sformatf("d%0d overrun", d),   g_ov, 32'((!cs && n > lim) ? 1 : 0));
      check($sformatf("d%0d state", d),     g_st, 32'(es));
    end
  endtask

  // Bit the master should see ahead of the next rising edge.
  task automatic check_miso();
    for (int d = 0; d < 2; d++) begin
      logic exp;
      logic got;
      got = (d == 0) ? bus1.MISO : bus2.MISO;
      if (cs || n >= fnum[d] * FS) exp = 1'b0;
      else                         exp = tx[FS-1 - (n % FS)];
      check($sformatf("d%0d miso", d), 32'(got), 32'(exp));
      if (!cs) cap[d] = {cap[d][FS-2:0], got};
    end
  endtask

  task automatic clk_edge(input logic b);
    mosi = b;
    #2 check_miso();
    #3 SCLK = 1'b1;
    if (!cs) begin
      for (int d = 0; d < 2; d++) begin
        if (n < fnum[d] * FS) begin
          if (n % FS == 0) begin
            m_valid[d] = 1'b0;
            acc[d]     = '0;
          end
          acc[d] = {acc[d][FS-2:0], b};
          if ((n + 1) % FS == 0) begin
            m_rx[d]    = acc[d];
            m_valid[d] = 1'b1;
            m_tog[d]   = ~m_tog[d];
          end
        end
      end
      n++;
    end
    #1 check_outputs();
    #4 SCLK = 1'b0;
  endtask

  task automatic set_cs(input logic v);
    cs = v;
    n  = 0;
    cap[0] = '0;
    cap[1] = '0;
    #2 check_outputs();
    if (v) check_miso();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    n   = 0;
    for (int d = 0; d < 2; d++) begin
      m_rx[d] = '0; m_valid[d] = 1'b0; m_tog[d] = 1'b0; acc[d] = '0;
    end
    #2 check_outputs();
    rst = 1'b0;
    #2;
  endtask

  task automatic send_frame(input logic [FS-1:0] data, input logic [FS-1:0] txw);
    tx = txw;
    for (int i = FS - 1; i >= 0; i--) clk_edge(data[i]);
  endtask

  initial begin
    n = 0;
    for (int d = 0; d < 2; d++) begin
      m_rx[d] = '0; m_valid[d] = 1'b0; m_tog[d] = 1'b0; acc[d] = '0; cap[d] = '0;
    end
    #3 do_reset();

    // Two frames: instance 1 finishes after the first and overruns on the second.
    set_cs(1'b0);
    send_frame(8'h12, 8'h3C);
    check("single miso capture", 32'(cap[0]), 32'h3C);
    check("two-frame f_cnt after 8", 32'(bus2.f_cnt_o), 32'd1);
    check("single done", 32'(bus1.done_o), 32'd1);
    send_frame(8'hFE, 8'hFF);
    check("two-frame rx_data", 32'(bus2.rx_data_o), 32'hFE);
    check("two-frame toggle", 32'(bus2.rx_toggle_o), 32'd0);
    check("two-frame done", 32'(bus2.done_o), 32'd1);
    check("overrun flag", 32'(bus1.overrun_o), 32'd1);
    check("overrun holds rx", 32'(bus1.rx_data_o), 32'h12);
    check("done miso idle", 32'(bus1.MISO), 32'd0);
    set_cs(1'b1);
    check("cs clears overrun", 32'(bus1.overrun_o), 32'd0);

    // Abort after five bits, then a clean frame.
    set_cs(1'b0);
    tx = 8'h00;
    for (int i = 7; i >= 3; i--) begin
      logic [FS-1:0] w;
      w = 8'h81;
      clk_edge(w[i]);
    end
    set_cs(1'b1);
    check("abort keeps rx", 32'(bus2.rx_data_o), 32'hFE);
    set_cs(1'b0);
    send_frame(8'h81, 8'h5A);
    check("after abort rx", 32'(bus1.rx_data_o), 32'h81);
    set_cs(1'b1);

    // Reset mid-frame.
    set_cs(1'b0);
    tx = 8'hA5;
    clk_edge(1'b1); clk_edge(1'b0); clk_edge(1'b1);
    do_reset();
    send_frame(8'h5A, 8'h96);
    check("after reset rx", 32'(bus2.rx_data_o), 32'h5A);
    set_cs(1'b1);

    // Random transactions, with occasional resets and edges while deselected.
    for (int t = 0; t < 60; t++) begin
      int ne;
      if ($urandom_range(0, 4) == 0) clk_edge(1'($urandom));
      set_cs(1'b0);
      ne = $urandom_range(0, 2 * FS + 4);
      for (int e = 0; e < ne; e++) begin
        if (n % FS == 0) tx = FS'($urandom);
        clk_edge(1'($urandom));
        if ($urandom_range(0, 40) == 0) do_reset();
      end
      set_cs(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
